// File: rtl/nx_node_store_pkg.sv
// Shared constants and types for the multi-port node store.
// - DEF_* : default parameter values used by nx_node_store_mp and its bench
// - instr_t / ctrl_t : instruction word and control entry at default widths
// - addr_bits() : address width helper for a power-of-two depth
package nx_node_store_pkg;

  localparam int unsigned DEF_INSTR_WIDTH = 15;
  localparam int unsigned DEF_MAX_INSTRS  = 512;
  localparam int unsigned DEF_CTRL_WIDTH  = 13;
  localparam int unsigned DEF_MAX_CTRL    = 512;
  localparam int unsigned DEF_FETCH_PORTS = 2;

  localparam int unsigned DEF_AW = $clog2(DEF_MAX_INSTRS);
  localparam int unsigned DEF_CW = $clog2(DEF_MAX_CTRL);

  typedef logic [DEF_INSTR_WIDTH-1:0] instr_t;
  typedef logic [DEF_CTRL_WIDTH-1:0]  ctrl_t;

  function automatic int unsigned addr_bits(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/nx_rr_arbiter.sv
// Round-robin arbiter for the instruction RAM port.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   req_i[N]      : per-channel request
//   en_i          : arbitration enable (low = no grant this cycle)
//   grant_o[N]    : one-hot grant, combinational
// The search starts at the channel after the last grant; the pointer
// only moves when a grant is actually issued.
module nx_rr_arbiter
  import nx_node_store_pkg::*;
#(
  parameter int unsigned N = DEF_FETCH_PORTS
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  // Offset i walks the priority order from ptr_q; channel j is matched by
  // comparison so every bit select uses a constant loop index.
  always_comb begin
    grant_o = '0;
    ptr_nxt = ptr_q;
    found   = 1'b0;
    if (en_i) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          if (!found && req_i[j] && (j == ((32'(ptr_q) + i) % N))) begin
            grant_o[j] = 1'b1;
            ptr_nxt    = PW'((j + 1) % N);
            found      = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= ptr_nxt;
    end
  end

endmodule

// File: rtl/nx_node_store_mp.sv
// Multi-port node store: one sequentially loaded instruction RAM shared by
// FETCH_PORTS fetch channels (round-robin, load has priority) and one
// control RAM with its own registered read port.
// Ports:
//   clk_i, rst_ni                  : clock, async active-low reset
//   instr_count_o                  : populated instruction count (0..MAX_INSTRS)
//   store_data_i, store_valid_i    : append port
//   store_full_o, store_ovf_o      : full flag, sticky overflow
//   fetch_addr_i, fetch_rd_i       : per-channel request
//   fetch_stall_o                  : request not granted this cycle
//   fetch_data_o, fetch_valid_o    : per-channel response, one cycle after grant
//   ctrl_addr_i, ctrl_wr_data_i,
//   ctrl_wr_en_i, ctrl_rd_en_i     : control RAM access
//   ctrl_rd_data_o                 : registered control read data
//   parity_err_o                   : sticky parity error (NX_NODE_STORE_PARITY_EN only)
// Build option: define NX_NODE_STORE_PARITY_EN to store an even-parity bit
// with every instruction and control entry and flag read mismatches.
module nx_node_store_mp
  import nx_node_store_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int unsigned MAX_INSTRS  = DEF_MAX_INSTRS,
  parameter int unsigned CTRL_WIDTH  = DEF_CTRL_WIDTH,
  parameter int unsigned MAX_CTRL    = DEF_MAX_CTRL,
  parameter int unsigned FETCH_PORTS = DEF_FETCH_PORTS
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  output logic [$clog2(MAX_INSTRS):0]                instr_count_o,
  input  logic [INSTR_WIDTH-1:0]                     store_data_i,
  input  logic                                       store_valid_i,
  output logic                                       store_full_o,
  output logic                                       store_ovf_o,
  input  logic [FETCH_PORTS*$clog2(MAX_INSTRS)-1:0]  fetch_addr_i,
  input  logic [FETCH_PORTS-1:0]                     fetch_rd_i,
  output logic [FETCH_PORTS-1:0]                     fetch_stall_o,
  output logic [FETCH_PORTS*INSTR_WIDTH-1:0]         fetch_data_o,
  output logic [FETCH_PORTS-1:0]                     fetch_valid_o,
  input  logic [$clog2(MAX_CTRL)-1:0]                ctrl_addr_i,
  input  logic [CTRL_WIDTH-1:0]                      ctrl_wr_data_i,
  input  logic                                       ctrl_wr_en_i,
  input  logic                                       ctrl_rd_en_i,
`ifdef NX_NODE_STORE_PARITY_EN
  output logic                                       parity_err_o,
`endif
  output logic [CTRL_WIDTH-1:0]                      ctrl_rd_data_o
);

  localparam int unsigned AW = $clog2(MAX_INSTRS);
`ifdef NX_NODE_STORE_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned IWS = INSTR_WIDTH + PB;
  localparam int unsigned CWS = CTRL_WIDTH + PB;

  logic [AW:0]              count_q;
  logic                     ovf_q;
  logic                     store_we;
  logic [FETCH_PORTS-1:0]   grant;
  logic [AW-1:0]            rd_addr;

  logic [IWS-1:0]           instr_mem [MAX_INSTRS];
  logic [CWS-1:0]           ctrl_mem  [MAX_CTRL];
  logic [IWS-1:0]           instr_wr_word;
  logic [IWS-1:0]           instr_rd_word;
  logic [CWS-1:0]           ctrl_wr_word;
  logic [CWS-1:0]           ctrl_rd_q;
  logic [INSTR_WIDTH-1:0]   fetch_q [FETCH_PORTS];

  // count is AW+1 bits so it saturates at MAX_INSTRS without wrapping.
  assign store_we      = store_valid_i && !count_q[AW];
  assign instr_count_o = count_q;
  assign store_full_o  = count_q[AW];
  assign store_ovf_o   = ovf_q;

  // A load write owns the single RAM port, so no fetch is granted that cycle.
  nx_rr_arbiter #(.N(FETCH_PORTS)) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (fetch_rd_i),
    .en_i    (!store_we),
    .grant_o (grant)
  );

  assign fetch_stall_o = fetch_rd_i & ~grant;

  always_comb begin
    rd_addr = '0;
    for (int unsigned p = 0; p < FETCH_PORTS; p++) begin
      if (grant[p]) rd_addr = fetch_addr_i[p*AW +: AW];
    end
  end

  assign instr_rd_word = instr_mem[rd_addr];

`ifdef NX_NODE_STORE_PARITY_EN
  assign instr_wr_word = {^store_data_i, store_data_i};
  assign ctrl_wr_word  = {^ctrl_wr_data_i, ctrl_wr_data_i};
`else
  assign instr_wr_word = store_data_i;
  assign ctrl_wr_word  = ctrl_wr_data_i;
`endif

  // RAM arrays are not reset.
  always_ff @(posedge clk_i) begin
    if (store_we)     instr_mem[count_q[AW-1:0]] <= instr_wr_word;
    if (ctrl_wr_en_i) ctrl_mem[ctrl_addr_i]      <= ctrl_wr_word;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q       <= '0;
      ovf_q         <= 1'b0;
      fetch_valid_o <= '0;
      ctrl_rd_q     <= '0;
      for (int unsigned p = 0; p < FETCH_PORTS; p++) fetch_q[p] <= '0;
    end else begin
      if (store_we)           count_q <= count_q + 1'b1;
      else if (store_valid_i) ovf_q   <= 1'b1;
      fetch_valid_o <= grant;
      for (int unsigned p = 0; p < FETCH_PORTS; p++) begin
        if (grant[p]) fetch_q[p] <= instr_rd_word[INSTR_WIDTH-1:0];
      end
      // Non-blocking read of the array returns pre-write data on a same-address rd+wr.
      if (ctrl_rd_en_i) ctrl_rd_q <= ctrl_mem[ctrl_addr_i];
    end
  end

  always_comb begin
    fetch_data_o = '0;
    for (int unsigned p = 0; p < FETCH_PORTS; p++) begin
      fetch_data_o[p*INSTR_WIDTH +: INSTR_WIDTH] = fetch_q[p];
    end
  end

  assign ctrl_rd_data_o = ctrl_rd_q[CTRL_WIDTH-1:0];

`ifdef NX_NODE_STORE_PARITY_EN
  logic par_err_q;

  // Checked on the word as it leaves the array; the data is still delivered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_err_q <= 1'b0;
    end else if (((|grant) && (^instr_rd_word)) ||
                 (ctrl_rd_en_i && (^ctrl_mem[ctrl_addr_i]))) begin
      par_err_q <= 1'b1;
    end
  end

  assign parity_err_o = par_err_q;
`endif

endmodule

// File: tb/tb_nx_node_store_mp.sv
module tb_nx_node_store_mp;
  import nx_node_store_pkg::*;

  localparam int unsigned IW  = DEF_INSTR_WIDTH;
  localparam int unsigned MI  = DEF_MAX_INSTRS;
  localparam int unsigned MC  = DEF_MAX_CTRL;
  localparam int unsigned FP  = DEF_FETCH_PORTS;
  localparam int unsigned AW  = $clog2(MI);
  localparam int unsigned CAW = $clog2(MC);

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic [AW:0]       instr_count;
  instr_t            store_data = '0;
  logic              store_valid = 1'b0;
  logic              store_full, store_ovf;
  logic [FP*AW-1:0]  fetch_addr = '0;
  logic [FP-1:0]     fetch_rd = '0;
  logic [FP-1:0]     fetch_stall, fetch_valid;
  logic [FP*IW-1:0]  fetch_data;
  logic [CAW-1:0]    ctrl_addr = '0;
  ctrl_t             ctrl_wr_data = '0;
  logic              ctrl_wr_en = 1'b0;
  logic              ctrl_rd_en = 1'b0;
  ctrl_t             ctrl_rd_data;
`ifdef NX_NODE_STORE_PARITY_EN
  logic              parity_err;
`endif

  always #5 clk = ~clk;

  nx_node_store_mp #(
    .INSTR_WIDTH (IW),
    .MAX_INSTRS  (MI),
    .CTRL_WIDTH  (DEF_CTRL_WIDTH),
    .MAX_CTRL    (MC),
    .FETCH_PORTS (FP)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .instr_count_o  (instr_count),
    .store_data_i   (store_data),
    .store_valid_i  (store_valid),
    .store_full_o   (store_full),
    .store_ovf_o    (store_ovf),
    .fetch_addr_i   (fetch_addr),
    .fetch_rd_i     (fetch_rd),
    .fetch_stall_o  (fetch_stall),
    .fetch_data_o   (fetch_data),
    .fetch_valid_o  (fetch_valid),
    .ctrl_addr_i    (ctrl_addr),
    .ctrl_wr_data_i (ctrl_wr_data),
    .ctrl_wr_en_i   (ctrl_wr_en),
    .ctrl_rd_en_i   (ctrl_rd_en),
`ifdef NX_NODE_STORE_PARITY_EN
    .parity_err_o   (parity_err),
`endif
    .ctrl_rd_data_o (ctrl_rd_data)
  );

  // Reference model state
  instr_t          imem_m [MI];
  ctrl_t           cmem_m [MC];
  int unsigned     count_m = 0;
  bit              ovf_m = 1'b0;
  int unsigned     last_g = FP - 1;
  logic [AW-1:0]   addr_a [FP];
  logic [FP-1:0]   g_m = '0;

  typedef struct packed {
    logic [7:0] ch;
    instr_t     d;
  } fexp_t;

  fexp_t           fetch_q [$];
  ctrl_t           ctrl_q [$];
  logic [FP-1:0]   stall_q [$];
  int unsigned     cnt_q [$];
  bit              ovf_q [$];

  int              errors = 0;
  int              checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: inputs are already set (at posedge+1). The model
  // predicts this cycle's stalls/status and the responses of the next.
  task automatic tick();
    bit          we;
    bit          found;
    int unsigned c;
    int unsigned gc;
    fexp_t       e;
    for (int unsigned p = 0; p < FP; p++) fetch_addr[p*AW +: AW] = addr_a[p];
    we    = store_valid && (count_m < MI);
    g_m   = '0;
    found = 1'b0;
    gc    = 0;
    if (!we) begin
      for (int unsigned k = 1; k <= FP; k++) begin
        c = (last_g + k) % FP;
        if (!found && fetch_rd[c]) begin
          found = 1'b1;
          gc    = c;
        end
      end
    end
    if (found) begin
      g_m[gc] = 1'b1;
      e.ch    = 8'(gc);
      e.d     = imem_m[addr_a[gc]];
      fetch_q.push_back(e);
      last_g  = gc;
    end
    stall_q.push_back(fetch_rd & ~g_m);
    cnt_q.push_back(count_m);
    ovf_q.push_back(ovf_m);
    if (ctrl_rd_en) ctrl_q.push_back(cmem_m[ctrl_addr]);
    if (ctrl_wr_en) cmem_m[ctrl_addr] = ctrl_wr_data;
    if (we) begin
      imem_m[count_m] = store_data;
      count_m++;
    end else if (store_valid) begin
      ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    store_valid = 1'b0;
    fetch_rd    = '0;
    ctrl_wr_en  = 1'b0;
    ctrl_rd_en  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    store_valid = 1'b0;
    fetch_rd    = '0;
    ctrl_wr_en  = 1'b0;
    ctrl_rd_en  = 1'b0;
    fetch_q.delete();
    ctrl_q.delete();
    stall_q.delete();
    cnt_q.delete();
    ovf_q.delete();
    count_m = 0;
    ovf_m   = 1'b0;
    last_g  = FP - 1;
    #2;
    chk("rst_count", instr_count, 0);
    chk("rst_full", store_full, 0);
    chk("rst_ovf", store_ovf, 0);
    chk("rst_valid", fetch_valid, 0);
    chk("rst_stall", fetch_stall, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic rand_phase(input int unsigned n, input int unsigned load_pct);
    for (int unsigned i = 0; i < n; i++) begin
      store_valid = ($urandom_range(0, 99) < load_pct);
      store_data  = instr_t'($urandom);
      // A stalled channel keeps its request; a granted or idle one picks anew.
      for (int unsigned p = 0; p < FP; p++) begin
        if (!fetch_rd[p] || g_m[p]) begin
          if (count_m > 0 && $urandom_range(0, 3) != 0) begin
            fetch_rd[p] = 1'b1;
            addr_a[p]   = AW'($urandom_range(0, count_m - 1));
          end else begin
            fetch_rd[p] = 1'b0;
          end
        end
      end
      ctrl_addr    = CAW'($urandom);
      ctrl_wr_data = ctrl_t'($urandom);
      ctrl_wr_en   = 1'($urandom_range(0, 1));
      ctrl_rd_en   = 1'($urandom_range(0, 1));
      tick();
    end
    idle(2);
  endtask

  // Monitor: pops expectations whenever the DUT presents a response.
  logic        rd_fire_d = 1'b0;
  instr_t      last_d [FP];
  ctrl_t       ctrl_hold = '0;
  fexp_t       me;
  int unsigned exp_cnt;

  always @(posedge clk) rd_fire_d <= ctrl_rd_en && rst_ni;

  initial for (int unsigned p = 0; p < FP; p++) last_d[p] = '0;

  always @(negedge clk) begin
    if (!rst_ni) begin
      for (int unsigned p = 0; p < FP; p++) last_d[p] = '0;
      ctrl_hold = '0;
      chk("valid_in_reset", fetch_valid, 0);
    end else begin
      if (stall_q.size() > 0) chk("stall", fetch_stall, stall_q.pop_front());
      if (cnt_q.size() > 0) begin
        exp_cnt = cnt_q.pop_front();
        chk("count", instr_count, exp_cnt);
        chk("full", store_full, 32'(exp_cnt == MI));
        chk("ovf", store_ovf, 32'(ovf_q.pop_front()));
      end
      for (int unsigned p = 0; p < FP; p++) begin
        if (fetch_valid[p]) begin
          if (fetch_q.size() == 0) begin
            chk("valid_unexpected", fetch_valid[p], 0);
          end else begin
            me = fetch_q.pop_front();
            chk("valid_channel", p, 32'(me.ch));
            last_d[me.ch] = me.d;
          end
        end
      end
      for (int unsigned p = 0; p < FP; p++) chk("fetch_data", fetch_data[p*IW +: IW], last_d[p]);
      if (rd_fire_d && ctrl_q.size() > 0) ctrl_hold = ctrl_q.pop_front();
      chk("ctrl_rd_data", ctrl_rd_data, ctrl_hold);
    end
  end

  initial begin
    for (int unsigned p = 0; p < FP; p++) addr_a[p] = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Load three words, fetch ch0 @1.
    for (int unsigned w = 1; w <= 3; w++) begin
      store_valid = 1'b1;
      store_data  = instr_t'(w);
      tick();
    end
    store_valid = 1'b0;
    fetch_rd    = 2'b01;
    addr_a[0]   = 9'd1;
    tick();
    chk("fetch_ch0_addr1", fetch_data[IW-1:0], 32'h2);
    idle(1);
    chk("count_after_3", instr_count, 3);

    // Both channels request every cycle: grants alternate.
    fetch_rd  = 2'b11;
    addr_a[0] = 9'd0;
    addr_a[1] = 9'd2;
    repeat (4) tick();
    idle(1);

    // Load and fetch collide: load wins, fetch granted next cycle.
    store_valid = 1'b1;
    store_data  = 15'h4;
    fetch_rd    = 2'b01;
    addr_a[0]   = 9'd2;
    tick();
    store_valid = 1'b0;
    tick();
    idle(2);

    // Initialise every control entry, then same-cycle rd+wr @5.
    for (int unsigned a = 0; a < MC; a++) begin
      ctrl_wr_en   = 1'b1;
      ctrl_addr    = CAW'(a);
      ctrl_wr_data = ctrl_t'($urandom);
      tick();
    end
    ctrl_addr    = 9'd5;
    ctrl_wr_data = 13'h155;
    ctrl_wr_en   = 1'b1;
    ctrl_rd_en   = 1'b1;
    tick();
    ctrl_wr_en = 1'b0;
    tick();
    idle(1);
    chk("ctrl_readback_155", ctrl_rd_data, 32'h155);

    // Fill to capacity, then one more append.
    while (count_m < MI) begin
      store_valid = 1'b1;
      store_data  = instr_t'($urandom);
      tick();
    end
    tick();
    idle(1);
    chk("fill_count", instr_count, MI);
    chk("fill_full", store_full, 1);
    chk("fill_ovf", store_ovf, 1);
    fetch_rd  = 2'b01;
    addr_a[0] = 9'd0;
    tick();
    chk("refetch_ram0", fetch_data[IW-1:0], 32'h1);
    idle(1);

    rand_phase(300, 30);

    // Reset with a grant in flight.
    fetch_rd  = 2'b10;
    addr_a[1] = 9'd7;
    tick();
    do_reset();
    idle(3);
    chk("post_rst_count", instr_count, 0);
    chk("post_rst_ovf", store_ovf, 0);

    rand_phase(600, 40);

    idle(3);
    chk("fetch_q_drained", fetch_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
